// File: rtl/valve_sequencer.sv
// Valve sequencer: staggered solenoid opening, min/max on-time
// and a latched fault shutdown for the irrigation controller.
module valve_sequencer #(
  parameter int STAGGER_CYC = 4,
  parameter int MIN_ON_CYC  = 8,
  parameter int MAX_ON_CYC  = 64,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] R1,
  input  logic [1:0] R2,
  input  logic [1:0] E,
  input  logic       fault_clr,
  output logic [3:0] V,
  output logic       pump_on,
  output logic       busy,
  output logic       fault,
  output logic [3:0] timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLT
  } state_e;

  localparam logic [CW-1:0] STAG_LD = CW'(STAGGER_CYC - 1);
  localparam logic [CW-1:0] MIN_LIM = CW'(MIN_ON_CYC - 1);
  localparam logic [CW-1:0] MAX_LIM = CW'(MAX_ON_CYC - 1);

  state_e          state_q, state_d;
  logic [3:0]      req_q;
  logic            err_q;
  logic [3:0]      v_q, v_d;
  logic [3:0]      lock_q, lock_d;
  logic [3:0]      tmo_q, tmo_d;
  logic            fault_q, fault_d;
  logic            pump_q, pump_d;
  logic [CW-1:0]   stag_q, stag_d;
  logic [CW-1:0]   on_q [4];
  logic [CW-1:0]   on_d [4];

  logic [3:0]      cand, pick, wd, nclose;

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    lock_d  = lock_q;
    tmo_d   = tmo_q;
    fault_d = fault_q;
    stag_d  = (stag_q != '0) ? stag_q - CW'(1) : '0;
    cand    = req_q & ~v_q & ~lock_q;
    pick    = cand & (~cand + 4'd1);
    wd      = '0;
    nclose  = '0;
    for (int i = 0; i < 4; i++) begin
      wd[i]     = v_q[i] & req_q[i] & (on_q[i] == MAX_LIM);
      nclose[i] = v_q[i] & ~req_q[i] & (on_q[i] >= MIN_LIM);
      on_d[i]   = (v_q[i] && on_q[i] != MAX_LIM) ?
                  on_q[i] + CW'(1) : on_q[i];
    end

    if (err_q) begin
      v_d     = '0;
      fault_d = 1'b1;
      lock_d  = '0;
      state_d = FLT;
    end else if (state_q == FLT) begin
      if (fault_clr) begin
        fault_d = 1'b0;
        tmo_d   = '0;
        stag_d  = '0;
        state_d = IDLE;
      end
    end else begin
      v_d    = v_q & ~(wd | nclose);
      lock_d = (lock_q & req_q) | wd;
      tmo_d  = (fault_clr ? 4'b0 : tmo_q) | wd;
      // candidates exclude open valves, so a closer never reopens here
      if (cand != '0 && stag_q == '0) begin
        v_d    = v_d | pick;
        stag_d = STAG_LD;
        for (int i = 0; i < 4; i++)
          if (pick[i]) on_d[i] = '0;
      end
      state_d = (v_d != '0) ? ACTIVE : IDLE;
    end
    pump_d = |v_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      err_q   <= 1'b0;
      v_q     <= '0;
      lock_q  <= '0;
      tmo_q   <= '0;
      fault_q <= 1'b0;
      pump_q  <= 1'b0;
      stag_q  <= '0;
      for (int i = 0; i < 4; i++) on_q[i] <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= {R2, R1};
      err_q   <= (E != 2'b01);
      v_q     <= v_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
      pump_q  <= pump_d;
      stag_q  <= stag_d;
      for (int i = 0; i < 4; i++) on_q[i] <= on_d[i];
    end
  end

  assign V       = v_q;
  assign pump_on = pump_q;
  assign busy    = pump_q;
  assign fault   = fault_q;
  assign timeout = tmo_q;

endmodule

// File: tb/tb_valve_sequencer.sv
// Bench for valve_sequencer: vector table, corner sequences,
// and random stimulus against an age-based reference model.
module tb_valve_sequencer;

  localparam int STAG = 4;
  localparam int MINC = 8;
  localparam int MAXC = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] R1 = 2'b00;
  logic [1:0] R2 = 2'b00;
  logic [1:0] E = 2'b01;
  logic       fault_clr = 1'b0;
  logic [3:0] V;
  logic       pump_on;
  logic       busy;
  logic       fault;
  logic [3:0] timeout;

  valve_sequencer dut (
    .clk(clk), .reset(reset), .R1(R1), .R2(R2), .E(E),
    .fault_clr(fault_clr), .V(V), .pump_on(pump_on),
    .busy(busy), .fault(fault), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // reference model: tracks when each valve opened and when the
  // last opening happened, in absolute edge numbers
  int         n = 0;
  logic [3:0] m_v, m_lock, m_tmo, m_req;
  logic       m_err, m_fault;
  int         open_at [4];
  int         last_open;

  task automatic model_reset();
    m_v = '0; m_lock = '0; m_tmo = '0; m_req = '0;
    m_err = 1'b0; m_fault = 1'b0;
    last_open = n - 1000;
    for (int i = 0; i < 4; i++) open_at[i] = n;
  endtask

  task automatic model_edge();
    logic [3:0] nv, wd;
    bit opened;
    n++;
    if (m_err) begin
      m_v = '0; m_fault = 1'b1; m_lock = '0;
    end else if (m_fault) begin
      if (fault_clr) begin
        m_fault = 1'b0; m_tmo = '0; last_open = n - 1000;
      end
    end else begin
      nv = m_v; wd = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_v[i]) begin
          int age;
          age = n - open_at[i];
          if (m_req[i] && age >= MAXC) begin
            nv[i] = 1'b0; wd[i] = 1'b1;
          end else if (!m_req[i] && age >= MINC) begin
            nv[i] = 1'b0;
          end
        end
      end
      if (n - last_open >= STAG) begin
        opened = 0;
        for (int i = 0; i < 4; i++)
          if (!opened && m_req[i] && !m_v[i] && !m_lock[i]) begin
            nv[i] = 1'b1; open_at[i] = n; last_open = n; opened = 1;
          end
      end
      m_lock = (m_lock & m_req) | wd;
      m_tmo  = (fault_clr ? 4'b0 : m_tmo) | wd;
      m_v    = nv;
    end
    m_req = {R2, R1};
    m_err = (E != 2'b01);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  typedef struct {
    int         cyc;
    logic [1:0] r1;
    logic [1:0] r2;
    logic [1:0] e;
    logic       fc;
    logic [3:0] v;
    logic       flt;
  } vec_t;

  vec_t tbl [13];

  task automatic pulse_len(input logic [1:0] r1v, input int hold,
                           output int hi);
    hi = 0;
    R1 = r1v;
    repeat (hold) begin tick(); if (V[0]) hi++; end
    R1 = 2'b00;
    repeat (20) begin tick(); if (V[0]) hi++; end
  endtask

  initial begin
    int hi;
    int errc;
    tbl[0]  = '{1, 2'b11, 2'b11, 2'b01, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{1, 2'b11, 2'b11, 2'b01, 1'b0, 4'b0001, 1'b0};
    tbl[2]  = '{3, 2'b11, 2'b11, 2'b01, 1'b0, 4'b0001, 1'b0};
    tbl[3]  = '{1, 2'b11, 2'b11, 2'b01, 1'b0, 4'b0011, 1'b0};
    tbl[4]  = '{4, 2'b11, 2'b11, 2'b01, 1'b0, 4'b0111, 1'b0};
    tbl[5]  = '{4, 2'b11, 2'b11, 2'b01, 1'b0, 4'b1111, 1'b0};
    tbl[6]  = '{1, 2'b11, 2'b11, 2'b00, 1'b0, 4'b1111, 1'b0};
    tbl[7]  = '{1, 2'b11, 2'b11, 2'b00, 1'b0, 4'b0000, 1'b1};
    tbl[8]  = '{1, 2'b11, 2'b11, 2'b00, 1'b1, 4'b0000, 1'b1};
    tbl[9]  = '{1, 2'b11, 2'b11, 2'b01, 1'b0, 4'b0000, 1'b1};
    tbl[10] = '{1, 2'b11, 2'b11, 2'b01, 1'b1, 4'b0000, 1'b0};
    tbl[11] = '{1, 2'b11, 2'b11, 2'b01, 1'b0, 4'b0001, 1'b0};
    tbl[12] = '{4, 2'b11, 2'b11, 2'b01, 1'b0, 4'b0011, 1'b0};

    model_reset();
    R1 = 2'b11; R2 = 2'b11; E = 2'b01;
    repeat (3) begin
      tick();
      check("rst_hold", {27'b0, V, pump_on, busy, fault, timeout} >> 0,
            32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    foreach (tbl[k]) begin
      R1 = tbl[k].r1; R2 = tbl[k].r2;
      E = tbl[k].e; fault_clr = tbl[k].fc;
      repeat (tbl[k].cyc) tick();
      check($sformatf("tbl%0d_v", k), {28'b0, V}, {28'b0, tbl[k].v});
      check($sformatf("tbl%0d_pump", k), {31'b0, pump_on},
            {31'b0, |tbl[k].v});
      check($sformatf("tbl%0d_fault", k), {31'b0, fault},
            {31'b0, tbl[k].flt});
    end
    check("tbl_tmo", {28'b0, timeout}, 32'h0);
    fault_clr = 1'b0;

    R1 = 2'b00; R2 = 2'b00;
    repeat (20) tick();
    pulse_len(2'b01, 3, hi);
    check("min_on_len", hi, 8);
    pulse_len(2'b01, 20, hi);
    check("req_len", hi, 20);

    R1 = 2'b10; hi = 0;
    repeat (100) begin tick(); if (V[1]) hi++; end
    check("wd_len", hi, 64);
    check("wd_held_v", {31'b0, V[1]}, 32'h0);
    check("wd_tmo", {28'b0, timeout}, 32'h2);
    R1 = 2'b00; tick();
    R1 = 2'b10; tick();
    check("reopen_wait", {31'b0, V[1]}, 32'h0);
    tick();
    check("reopen_v", {31'b0, V[1]}, 32'h1);
    check("reopen_tmo", {28'b0, timeout}, 32'h2);
    R1 = 2'b00;
    repeat (20) tick();
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    check("tmo_clr", {28'b0, timeout}, 32'h0);

    R1 = 2'b11; R2 = 2'b11;
    repeat (14) tick();
    check("pre_rst_v", {28'b0, V}, 32'hf);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("async_rst_v", {28'b0, V}, 32'h0);
    check("async_rst_pump", {31'b0, pump_on}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("restart_wait", {28'b0, V}, 32'h0);
    tick();
    check("restart_v", {28'b0, V}, 32'h1);
    repeat (4) tick();
    check("restart_stag", {28'b0, V}, 32'h3);

    reset = 1'b0;
    model_reset();
    R1 = 2'b00; R2 = 2'b00; E = 2'b01; fault_clr = 1'b0;
    tick();
    @(negedge clk);
    reset = 1'b1;
    errc = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        R1 = 2'($urandom); R2 = 2'($urandom);
      end
      if (errc > 0) begin
        errc--;
        E = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      end else begin
        E = 2'b01;
        if ($urandom_range(0, 249) == 0) errc = $urandom_range(1, 4);
      end
      fault_clr = ($urandom_range(0, 15) == 0);
      tick();
      check("model", {21'b0, V, pump_on, busy, fault, timeout},
            {21'b0, m_v, |m_v, |m_v, m_fault, m_tmo});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
